// File: rtl/arb_mux_nx1.sv
// arb_mux_nx1
//   N_IN-input, WIDTH-bit arbitrated multiplexer with a one-entry registered output.
//   An internal arbiter (round-robin or fixed lowest-index priority) picks one valid
//   producer. The selected word is loaded into the output register whenever the
//   register is empty or is being consumed in the same cycle.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   mode       0 = round-robin, 1 = fixed priority (lowest index wins)
//   in_data    packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, one-hot or zero
//   out_data   registered selected data
//   out_valid  out_data holds an unconsumed word
//   out_ready  consumer accepts out_data this cycle
//   out_sel    index of the channel that produced out_data

module arb_mux_nx1 #(
    parameter int WIDTH = 32,
    parameter int N_IN  = 8,
    parameter int SEL_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mode,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]       in_valid,
    output logic [N_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      out_sel
);

    logic [SEL_W-1:0] rr_ptr_q;
    logic [SEL_W-1:0] sel_q;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    logic [SEL_W-1:0] grant;
    logic             any_valid;
    logic             can_load;
    logic             transfer;
    logic [WIDTH-1:0] grant_data;

    // Grant among valid channels. Loops run from the last candidate back to the
    // first so the final assignment is the winner in search order.
    always_comb begin
        int idx;
        grant     = '0;
        any_valid = 1'b0;
        idx       = 0;
        if (mode) begin
            for (int i = N_IN - 1; i >= 0; i--) begin
                if (in_valid[i]) begin
                    grant     = SEL_W'(i);
                    any_valid = 1'b1;
                end
            end
        end else begin
            for (int k = N_IN - 1; k >= 0; k--) begin
                idx = (int'(rr_ptr_q) + k) % N_IN;
                if (in_valid[idx]) begin
                    grant     = SEL_W'(idx);
                    any_valid = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (grant == SEL_W'(i)) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign can_load = !valid_q || out_ready;

    // Nothing is acknowledged while reset is held, even though the registers
    // are already cleared asynchronously.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (any_valid && can_load && !reset && grant == SEL_W'(i)) begin
                in_ready[i] = 1'b1;
            end
        end
    end

    assign transfer = |(in_ready & in_valid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            sel_q    <= '0;
            rr_ptr_q <= '0;
        end else if (transfer) begin
            valid_q <= 1'b1;
            data_q  <= grant_data;
            sel_q   <= grant;
            if (!mode) begin
                rr_ptr_q <= (grant == SEL_W'(N_IN - 1)) ? '0 : grant + 1'b1;
            end
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_sel   = sel_q;

endmodule

// File: tb/tb_arb_mux_nx1.sv
// tb_arb_mux_nx1
//   Directed bench for arb_mux_nx1 (WIDTH=32, N_IN=8). Inputs change 1 ns after the
//   rising edge; outputs are checked at that same offset.

module tb_arb_mux_nx1;

    localparam int WIDTH = 32;
    localparam int N_IN  = 8;
    localparam int SEL_W = 3;

    logic                  clk;
    logic                  reset;
    logic                  mode;
    logic [N_IN*WIDTH-1:0] in_data;
    logic [N_IN-1:0]       in_valid;
    logic [N_IN-1:0]       in_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [SEL_W-1:0]      out_sel;

    int n_checks;
    int n_fails;

    arb_mux_nx1 #(
        .WIDTH(WIDTH),
        .N_IN (N_IN),
        .SEL_W(SEL_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .mode     (mode),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sel  (out_sel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        reset     = 1'b1;
        mode      = 1'b0;
        out_ready = 1'b1;
        in_valid  = 8'hFF;
        for (int i = 0; i < N_IN; i++) begin
            in_data[i*WIDTH +: WIDTH] = 32'(100 + i);
        end

        // 1: reset with every channel valid
        #12;
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_sel", 32'(out_sel), 32'h0);
        reset = 1'b0;
        #1;
        check("rr_first_ready", 32'(in_ready), 32'h01);

        // 2: round-robin, all valid: 0..7 then wrap to 0
        for (int i = 0; i < 9; i++) begin
            tick();
            check("rr_sel", 32'(out_sel), 32'(i % 8));
            check("rr_data", out_data, 32'(100 + (i % 8)));
            check("rr_valid", 32'(out_valid), 32'h1);
        end
        // rr_ptr is now 1

        // 3: fixed priority
        mode     = 1'b1;
        in_valid = 8'b1010_0100;
        #1;
        check("fp_ready_ch2", 32'(in_ready), 32'h04);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fp_sel_ch2", 32'(out_sel), 32'd2);
            check("fp_data_ch2", out_data, 32'd102);
        end
        in_valid = 8'b1010_0000;
        #1;
        check("fp_ready_ch5", 32'(in_ready), 32'h20);
        tick();
        check("fp_sel_ch5", 32'(out_sel), 32'd5);
        check("fp_data_ch5", out_data, 32'd105);

        // 4: backpressure
        in_valid                  = 8'b0000_1000;
        in_data[3*WIDTH +: WIDTH] = 32'hDEAD_BEEF;
        tick();
        check("bp_load_data", out_data, 32'hDEAD_BEEF);
        check("bp_load_sel", 32'(out_sel), 32'd3);
        out_ready                 = 1'b0;
        in_data[3*WIDTH +: WIDTH] = 32'h1234_5678;
        #1;
        check("bp_ready_low", 32'(in_ready), 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_data", out_data, 32'hDEAD_BEEF);
            check("bp_hold_sel", 32'(out_sel), 32'd3);
            check("bp_hold_valid", 32'(out_valid), 32'h1);
            check("bp_hold_ready", 32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'h08);
        tick();
        check("bp_next_data", out_data, 32'h1234_5678);
        in_data[3*WIDTH +: WIDTH] = 32'd103;

        // 5: move rr_ptr to 6 via channel 5, then sparse valids wrap around
        mode     = 1'b0;
        in_valid = 8'b0010_0000;
        tick();
        check("rr6_setup_sel", 32'(out_sel), 32'd5);
        in_valid = 8'b0000_0011;
        #1;
        check("wrap_ready_ch0", 32'(in_ready), 32'h01);
        tick();
        check("wrap_sel_a", 32'(out_sel), 32'd0);
        check("wrap_ready_ch1", 32'(in_ready), 32'h02);
        tick();
        check("wrap_sel_b", 32'(out_sel), 32'd1);
        check("wrap_data_b", out_data, 32'd101);
        tick();
        check("wrap_sel_c", 32'(out_sel), 32'd0);
        check("wrap_data_c", out_data, 32'd100);

        // 6: asynchronous reset between edges while a word is held
        in_valid  = 8'h00;
        out_ready = 1'b0;
        tick();
        check("ar_pre_valid", 32'(out_valid), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_valid", 32'(out_valid), 32'h0);
        check("ar_data", out_data, 32'h0);
        check("ar_sel", 32'(out_sel), 32'h0);
        in_valid  = 8'b1000_0001;
        out_ready = 1'b1;
        #1;
        check("ar_ready_in_reset", 32'(in_ready), 32'h0);
        reset = 1'b0;
        #1;
        // rr_ptr back at 0 so channel 0 wins over channel 7
        check("ar_rr_ptr_cleared", 32'(in_ready), 32'h01);
        tick();
        check("ar_after_sel", 32'(out_sel), 32'd0);
        check("ar_after_valid", 32'(out_valid), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
